// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard controller and mult/div unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: mult/div FSM state encoding, the hardwired zero register index,
// and the default mult/div latency shared with the mult/div datapath.
package hazard_unit_pkg;

  // Mult/div occupancy FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_t;

  // $zero is hardwired and can never carry a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default mult/div latency in cycles; the mult/div unit uses the same value
  localparam int MD_LAT_DEFAULT = 32;

endpackage

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, mult/div busy.
// Latency: decisions are combinational from ID/EX inputs plus FSM state (0 cycles).
// Backpressure: stall drops pc_write/ifid_write and bubbles ID/EX; a taken branch overrides any stall.
//
// Ports:
//   clk, rst           pipeline clock, async active-high reset
//   id_rs, id_rt       source register fields of the ID instruction
//   id_useRt           ID instruction reads rt
//   id_mdStart         ID instruction is mult/multu/div/divu
//   id_mdRead          ID instruction is mfhi/mflo/mthi/mtlo
//   ex_rw              destination register of the EX instruction
//   ex_memRd           EX instruction is a load
//   ex_regWr           EX instruction writes the register file
//   ex_branchTaken     branch/jump in EX is taken this cycle
//   pc_write           PC load enable
//   ifid_write         IF/ID load enable
//   ifid_flush         clear IF/ID to a nop at the next edge
//   idex_flush         load a bubble into ID/EX at the next edge
//   md_busy            mult/div unit occupied
//   md_done            pulse in the final busy cycle
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_useRt,
  input  logic       id_mdStart,
  input  logic       id_mdRead,
  input  logic [4:0] ex_rw,
  input  logic       ex_memRd,
  input  logic       ex_regWr,
  input  logic       ex_branchTaken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  logic load_use;
  logic md_hazard;
  logic stall;
  logic stall_eff;
  logic flush_eff;
  logic md_accept;

  // Hazard detection. A load-use stall needs no state: one cycle later the
  // load sits in MEM and the forwarding unit covers the dependency.
  assign load_use = ex_memRd & ex_regWr & (ex_rw != REG_ZERO) &
                    ((ex_rw == id_rs) | (id_useRt & (ex_rw == id_rt)));

  assign md_hazard = (state == ST_MD_BUSY) & (id_mdStart | id_mdRead);
  assign stall     = load_use | md_hazard;

  // Reset is folded in here so every output is at its reset value
  // immediately on assertion, regardless of what ID/EX present.
  assign flush_eff = ex_branchTaken & ~rst;
  assign stall_eff = stall & ~ex_branchTaken & ~rst;

  assign pc_write   = ~stall_eff;
  assign ifid_write = ~stall_eff;
  assign ifid_flush = flush_eff;
  assign idex_flush = flush_eff | stall_eff;

  // A start is only accepted when the instruction actually leaves ID this cycle
  assign md_accept = id_mdStart & ~stall & ~ex_branchTaken;

  // Mult/div occupancy. The counter is loaded on the issue edge, so md_busy
  // covers MD_LAT-1 cycles and the stall releases in the first IDLE cycle.
  // A taken branch does not abort: the issuing instruction has already left ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_accept) begin
            state <= ST_MD_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_MD_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign md_busy = (state == ST_MD_BUSY);
  assign md_done = (state == ST_MD_BUSY) & (cnt == CNT_ONE);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MD_LAT=4.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
// Observed vector order: {pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done}.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_useRt;
  logic       id_mdStart;
  logic       id_mdRead;
  logic [4:0] ex_rw;
  logic       ex_memRd;
  logic       ex_regWr;
  logic       ex_branchTaken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_busy;
  logic       md_done;

  logic [5:0] obs;
  int         total;
  int         bad;

  hazard_unit #(.MD_LAT(4), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_useRt      (id_useRt),
    .id_mdStart    (id_mdStart),
    .id_mdRead     (id_mdRead),
    .ex_rw         (ex_rw),
    .ex_memRd      (ex_memRd),
    .ex_regWr      (ex_regWr),
    .ex_branchTaken(ex_branchTaken),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .md_busy       (md_busy),
    .md_done       (md_done)
  );

  assign obs = {pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle's stimulus point
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_useRt = 1'b0;
    id_mdStart = 1'b0; id_mdRead = 1'b0;
    ex_rw = 5'd0; ex_memRd = 1'b0; ex_regWr = 1'b0; ex_branchTaken = 1'b0;
  endtask

  task automatic test_reset();
    // Hazard-provoking inputs while in reset must not leak to the outputs
    ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd8; id_rs = 5'd8; id_mdStart = 1'b1;
    next_cycle();
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL reset_hold: got %b want %b", obs, 6'b110000); end
    clear_inputs();
    rst = 1'b0;
    next_cycle();
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL reset_first_cycle: got %b want %b", obs, 6'b110000); end
  endtask

  task automatic test_load_use_rs();
    ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd8; id_rs = 5'd8;
    #1; total++;
    if (obs !== 6'b000100) begin bad++; $display("FAIL lu_rs_stall: got %b want %b", obs, 6'b000100); end
    // Next cycle the load has moved to MEM; EX holds the bubble
    next_cycle();
    ex_memRd = 1'b0; ex_regWr = 1'b0; ex_rw = 5'd0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL lu_rs_release: got %b want %b", obs, 6'b110000); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_rt_and_zero();
    ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd8; id_rt = 5'd8; id_rs = 5'd9; id_useRt = 1'b0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL rt_unused: got %b want %b", obs, 6'b110000); end
    id_useRt = 1'b1;
    #1; total++;
    if (obs !== 6'b000100) begin bad++; $display("FAIL rt_used: got %b want %b", obs, 6'b000100); end
    id_useRt = 1'b0; ex_rw = 5'd0; id_rs = 5'd0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL reg_zero: got %b want %b", obs, 6'b110000); end
    ex_rw = 5'd8; id_rs = 5'd8; ex_regWr = 1'b0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL no_regwr: got %b want %b", obs, 6'b110000); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_branch_priority();
    ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd8; id_rs = 5'd8; ex_branchTaken = 1'b1;
    #1; total++;
    if (obs !== 6'b111100) begin bad++; $display("FAIL branch_over_lu: got %b want %b", obs, 6'b111100); end
    ex_memRd = 1'b0;
    #1; total++;
    if (obs !== 6'b111100) begin bad++; $display("FAIL branch_only: got %b want %b", obs, 6'b111100); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_md_latency();
    id_mdStart = 1'b1;                       // cycle 0
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL md_issue: got %b want %b", obs, 6'b110000); end
    next_cycle(); id_mdStart = 1'b0;         // cycle 1
    #1; total++;
    if (obs !== 6'b110010) begin bad++; $display("FAIL md_c1: got %b want %b", obs, 6'b110010); end
    next_cycle(); id_mdRead = 1'b1;          // cycle 2
    #1; total++;
    if (obs !== 6'b000110) begin bad++; $display("FAIL md_c2_stall: got %b want %b", obs, 6'b000110); end
    next_cycle();                            // cycle 3
    #1; total++;
    if (obs !== 6'b000111) begin bad++; $display("FAIL md_c3_done: got %b want %b", obs, 6'b000111); end
    next_cycle();                            // cycle 4
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL md_c4_release: got %b want %b", obs, 6'b110000); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    id_mdStart = 1'b1;                       // cycle 0: first issue
    next_cycle();                            // cycle 1: second start held
    #1; total++;
    if (obs !== 6'b000110) begin bad++; $display("FAIL b2b_c1: got %b want %b", obs, 6'b000110); end
    next_cycle();
    next_cycle();                            // cycle 3
    #1; total++;
    if (obs !== 6'b000111) begin bad++; $display("FAIL b2b_c3: got %b want %b", obs, 6'b000111); end
    next_cycle();                            // cycle 4: IDLE, second start accepted
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL b2b_accept: got %b want %b", obs, 6'b110000); end
    next_cycle(); id_mdStart = 1'b0;         // cycle 5
    #1; total++;
    if (obs !== 6'b110010) begin bad++; $display("FAIL b2b_busy_again: got %b want %b", obs, 6'b110010); end
    next_cycle();
    next_cycle();                            // cycle 7
    #1; total++;
    if (obs !== 6'b110011) begin bad++; $display("FAIL b2b_done2: got %b want %b", obs, 6'b110011); end
    next_cycle();                            // cycle 8
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL b2b_idle: got %b want %b", obs, 6'b110000); end
  endtask

  task automatic test_combined_stall();
    // Start blocked by a load-use must not be accepted
    id_mdStart = 1'b1; ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd5; id_rs = 5'd5;
    #1; total++;
    if (obs !== 6'b000100) begin bad++; $display("FAIL comb_start_blocked: got %b want %b", obs, 6'b000100); end
    next_cycle(); ex_memRd = 1'b0; ex_regWr = 1'b0; ex_rw = 5'd0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL comb_not_issued: got %b want %b", obs, 6'b110000); end
    next_cycle(); id_mdStart = 1'b0;         // cycle 1 of op
    next_cycle();                            // cycle 2
    next_cycle();                            // cycle 3: last busy cycle, both hazards
    id_mdRead = 1'b1; ex_memRd = 1'b1; ex_regWr = 1'b1; ex_rw = 5'd5;
    #1; total++;
    if (obs !== 6'b000111) begin bad++; $display("FAIL comb_both: got %b want %b", obs, 6'b000111); end
    next_cycle();                            // IDLE, load-use still present
    #1; total++;
    if (obs !== 6'b000100) begin bad++; $display("FAIL comb_lu_remains: got %b want %b", obs, 6'b000100); end
    next_cycle(); ex_memRd = 1'b0; ex_regWr = 1'b0; ex_rw = 5'd0;
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL comb_clear: got %b want %b", obs, 6'b110000); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_branch_during_md();
    id_mdStart = 1'b1;
    next_cycle(); id_mdStart = 1'b0; ex_branchTaken = 1'b1;   // cycle 1
    #1; total++;
    if (obs !== 6'b111110) begin bad++; $display("FAIL br_md_c1: got %b want %b", obs, 6'b111110); end
    next_cycle(); ex_branchTaken = 1'b0;                       // cycle 2
    #1; total++;
    if (obs !== 6'b110010) begin bad++; $display("FAIL br_md_c2: got %b want %b", obs, 6'b110010); end
    next_cycle();                                              // cycle 3
    #1; total++;
    if (obs !== 6'b110011) begin bad++; $display("FAIL br_md_done: got %b want %b", obs, 6'b110011); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    id_mdStart = 1'b1;
    next_cycle(); id_mdStart = 1'b0;         // cycle 1
    next_cycle(); id_mdRead = 1'b1;          // cycle 2: stalled
    #1; total++;
    if (obs !== 6'b000110) begin bad++; $display("FAIL rst_pre: got %b want %b", obs, 6'b000110); end
    rst = 1'b1;                              // asynchronous, mid-cycle
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL rst_async: got %b want %b", obs, 6'b110000); end
    next_cycle();
    rst = 1'b0; id_mdRead = 1'b0;
    next_cycle(); id_mdStart = 1'b1;         // first cycle after release
    #1; total++;
    if (obs !== 6'b110000) begin bad++; $display("FAIL rst_idle_accept: got %b want %b", obs, 6'b110000); end
    next_cycle(); id_mdStart = 1'b0;
    #1; total++;
    if (obs !== 6'b110010) begin bad++; $display("FAIL rst_new_busy: got %b want %b", obs, 6'b110010); end
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_load_use_rs();
    test_rt_and_zero();
    test_branch_priority();
    test_md_latency();
    test_back_to_back();
    test_combined_stall();
    test_branch_during_md();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
